seq_detect_ctrl: RTL and testbench
==================================

Name: seq_detect_ctrl

Overview:
- Controller that sequences a bit-serial pattern detector from a word-wide valid/ready stream.
- Accepts DATA_W-bit words, shifts them MSB-first through an internal programmable-pattern matcher (up to PAT_MAX bits, overlapping detection), counts matches, raises a sticky threshold interrupt.
- Sits between a word-oriented producer and status/interrupt logic; replaces per-pattern hardwired FSMs with one configurable scheduler.

Parameters:
DATA_W, 8, input word width; bits serialised MSB first
PAT_MAX, 8, maximum pattern length in bits (>=2)
CNT_W, 16, match counter width

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
enable  in  1  allow acceptance of new words
clear  in  1  synchronous clear of history/count/irq; aborts word in flight
cfg_pattern  in  PAT_MAX  pattern; bit [cfg_len-1] is the first bit expected, bit 0 the last
cfg_len  in  $clog2(PAT_MAX+1)  pattern length; 0 treated as 1, >PAT_MAX clamped to PAT_MAX
cfg_thresh  in  CNT_W  irq threshold; 0 disables irq
in_valid  in  1  word valid
in_data  in  DATA_W  word
in_ready  out  1  word accepted when in_valid && in_ready
det_pulse  out  1  one-cycle pulse per detected match
match_count  out  CNT_W  saturating match count
irq  out  1  sticky: match_count >= cfg_thresh (thresh != 0)
busy  out  1  word being serialised

Behaviour:
- Reset (async) and clear (sync, highest priority over all other events): state=IDLE, hist=0, fill=0, bit_idx=0, match_count=0, det_pulse=0, irq=0, busy=0. Clear mid-word discards the remaining bits; no pulse in the clear cycle.
- States: IDLE, SHIFT.
  - IDLE: in_ready = enable. On accept → SHIFT; word loaded into shift reg; cfg_pattern/cfg_len latched into shadow regs.
  - SHIFT: one bit per cycle, bit_idx 0..DATA_W-1. in_ready = enable && bit_idx==DATA_W-1 (gapless back-to-back streaming). At last bit: accept → stay SHIFT with bit_idx=0 and new word; else → IDLE.
- enable low mid-word: current word completes; no new accept.
- busy = (state==SHIFT), registered.
- Per shifted bit: hist <= {hist[PAT_MAX-2:0], bit}; fill <= min(fill+1, PAT_MAX).
- Match when the new fill >= len and new hist[len-1:0] == pattern[len-1:0] (shadow len/pattern).
- History persists across words and across IDLE gaps; only reset/clear flush it.
- Latency: word accepted in cycle T; bit i shifted at edge ending T+1+i; det_pulse high in cycle T+2+i (registered).
- match_count increments in the same cycle det_pulse is high; saturates at 2^CNT_W-1 (det_pulse still pulses).
- irq set in the cycle match_count first becomes >= cfg_thresh (cfg_thresh != 0); held until clear/reset. cfg_thresh changes do not clear irq.
- cfg_* changes while busy take effect at the next word accept.

Optional Feature:
DET_NONOVERLAP_EN
- Defined: on a match, fill <= 0 for the next bit, so matching bits are not reused (non-overlapping count).
- Undefined: overlapping detection; fill is unaffected by matches.

Test Plan:
- len=3, pattern=3'b101, accept 8'b1010_1000 at T → det_pulse at T+4 and T+6; match_count=2. With DET_NONOVERLAP_EN: single pulse at T+4; count=1.
- Cross-word: 101, words 8'h01 then 8'h40 back-to-back → in_ready high at T and T+8, busy continuous 16 cycles; one pulse at T+11 (word 2, bit 1).
- Threshold: cfg_thresh=3, stream 8'hAA words with pattern 2'b10, len=2 → irq rises in the same cycle match_count becomes 3; stays high after enable=0; clear → irq=0, count=0.
- Saturation: CNT_W=4, 20 matches → match_count stops at 15; det_pulse still fires 20 times.
- clear asserted at bit_idx=3 of 8'hFF with pattern 2'b11 → no further pulses from that word; state IDLE next cycle; in_ready=enable.
- Async reset mid-SHIFT → all outputs 0 immediately; after release, first accepted word detected with empty history (no matches from pre-reset bits).

Source files
------------

// File: rtl/seq_detect_ctrl.sv
// Word-stream to bit-serial programmable pattern detector with saturating match counter and sticky irq.
// Optional macro DET_NONOVERLAP_EN: matching bits are not reused (non-overlapping detection).
module seq_detect_ctrl #(
    parameter int DATA_W  = 8,
    parameter int PAT_MAX = 8,
    parameter int CNT_W   = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         enable,
    input  logic                         clear,
    input  logic [PAT_MAX-1:0]           cfg_pattern,
    input  logic [$clog2(PAT_MAX+1)-1:0] cfg_len,
    input  logic [CNT_W-1:0]             cfg_thresh,
    input  logic                         in_valid,
    input  logic [DATA_W-1:0]            in_data,
    output logic                         in_ready,
    output logic                         det_pulse,
    output logic [CNT_W-1:0]             match_count,
    output logic                         irq,
    output logic                         busy
);

    localparam int LEN_W = $clog2(PAT_MAX + 1);
    localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(PAT_MAX);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t             state_reg, state_next;
    logic [DATA_W-1:0]  shift_reg, shift_next;
    logic [IDX_W-1:0]   bit_idx_reg, bit_idx_next;
    logic [PAT_MAX-1:0] hist_reg, hist_next;
    logic [PAT_MAX-1:0] pat_reg, pat_next;
    logic [LEN_W-1:0]   len_reg, len_next;
    logic [LEN_W-1:0]   fill_reg, fill_next;
    logic [CNT_W-1:0]   count_reg, count_next;
    logic               det_reg, det_next;
    logic               irq_reg, irq_next;

    logic [PAT_MAX-1:0] len_mask;
    logic [PAT_MAX-1:0] hist_shifted;
    logic [LEN_W-1:0]   fill_inc;
    logic [LEN_W-1:0]   cfg_len_eff;
    logic               hit;

    // Only the low len bits of history/pattern take part in the compare.
    generate
        for (genvar gi = 0; gi < PAT_MAX; gi++) begin : g_mask
            assign len_mask[gi] = (gi < int'(len_reg));
        end
    endgenerate

    always_comb begin
        if (cfg_len == '0) begin
            cfg_len_eff = LEN_W'(1);
        end else if (cfg_len > LEN_MAX) begin
            cfg_len_eff = LEN_MAX;
        end else begin
            cfg_len_eff = cfg_len;
        end
    end

    assign hist_shifted = {hist_reg[PAT_MAX-2:0], shift_reg[DATA_W-1]};
    assign fill_inc     = (fill_reg >= LEN_MAX) ? LEN_MAX : fill_reg + LEN_W'(1);
    assign hit          = (fill_inc >= len_reg) && (((hist_shifted ^ pat_reg) & len_mask) == '0);

    always_comb begin
        state_next   = state_reg;
        shift_next   = shift_reg;
        bit_idx_next = bit_idx_reg;
        hist_next    = hist_reg;
        pat_next     = pat_reg;
        len_next     = len_reg;
        fill_next    = fill_reg;
        count_next   = count_reg;
        det_next     = 1'b0;
        irq_next     = irq_reg;
        in_ready     = 1'b0;

        case (state_reg)
            IDLE: begin
                in_ready = enable;
            end
            SHIFT: begin
                in_ready     = enable && (bit_idx_reg == IDX_LAST);
                hist_next    = hist_shifted;
                shift_next   = shift_reg << 1;
                bit_idx_next = bit_idx_reg + IDX_W'(1);
                fill_next    = fill_inc;
                if (hit) begin
                    det_next = 1'b1;
                    if (count_reg != CNT_MAX) begin
                        count_next = count_reg + CNT_W'(1);
                    end
`ifdef DET_NONOVERLAP_EN
                    fill_next = '0;
`endif
                end
                if (bit_idx_reg == IDX_LAST) begin
                    state_next   = IDLE;
                    bit_idx_next = '0;
                end
            end
            default: state_next = IDLE;
        endcase

        // A word offered during clear would be discarded, so refuse it instead.
        if (clear) begin
            in_ready = 1'b0;
        end

        if (in_valid && in_ready) begin
            state_next   = SHIFT;
            shift_next   = in_data;
            bit_idx_next = '0;
            pat_next     = cfg_pattern;
            len_next     = cfg_len_eff;
        end

        irq_next = irq_reg | ((cfg_thresh != '0) && (count_next >= cfg_thresh));

        if (clear) begin
            state_next   = IDLE;
            shift_next   = '0;
            bit_idx_next = '0;
            hist_next    = '0;
            fill_next    = '0;
            count_next   = '0;
            det_next     = 1'b0;
            irq_next     = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg   <= IDLE;
            shift_reg   <= '0;
            bit_idx_reg <= '0;
            hist_reg    <= '0;
            pat_reg     <= '0;
            len_reg     <= LEN_W'(1);
            fill_reg    <= '0;
            count_reg   <= '0;
            det_reg     <= 1'b0;
            irq_reg     <= 1'b0;
        end else begin
            state_reg   <= state_next;
            shift_reg   <= shift_next;
            bit_idx_reg <= bit_idx_next;
            hist_reg    <= hist_next;
            pat_reg     <= pat_next;
            len_reg     <= len_next;
            fill_reg    <= fill_next;
            count_reg   <= count_next;
            det_reg     <= det_next;
            irq_reg     <= irq_next;
        end
    end

    assign busy        = (state_reg == SHIFT);
    assign det_pulse   = det_reg;
    assign match_count = count_reg;
    assign irq         = irq_reg;

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Self-checking bench for seq_detect_ctrl: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a bit-queue reference model.
module tb_seq_detect_ctrl;

    localparam int DATA_W  = 8;
    localparam int PAT_MAX = 8;
    localparam int CNT_W   = 4;
    localparam int LEN_W   = $clog2(PAT_MAX + 1);

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               enable = 1'b0;
    logic               clear = 1'b0;
    logic [PAT_MAX-1:0] cfg_pattern = '0;
    logic [LEN_W-1:0]   cfg_len = '0;
    logic [CNT_W-1:0]   cfg_thresh = '0;
    logic               in_valid = 1'b0;
    logic [DATA_W-1:0]  in_data = '0;
    logic               in_ready;
    logic               det_pulse;
    logic [CNT_W-1:0]   match_count;
    logic               irq;
    logic               busy;

    seq_detect_ctrl #(.DATA_W(DATA_W), .PAT_MAX(PAT_MAX), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .enable(enable), .clear(clear),
        .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_thresh(cfg_thresh),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .det_pulse(det_pulse), .match_count(match_count), .irq(irq), .busy(busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int pulses[$];

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc = cyc + 1;

    // Reference model: remaining bits of the word in flight, recent history, and bits usable for a match.
    int   mq[$];
    int   hq[$];
    bit   mbusy = 0;
    int   avail = 0;
    logic [PAT_MAX-1:0] mpat = '0;
    int   mlen = 1;
    int   mcnt = 0;
    bit   mdet = 0;
    bit   mirq = 0;
    bit   m_rdy;
    bit   m_ok;
    int   m_b;

    always @(posedge clk or posedge reset) begin
        if (reset || clear) begin
            mq.delete();
            hq.delete();
            mbusy = 0;
            avail = 0;
            mcnt  = 0;
            mdet  = 0;
            mirq  = 0;
        end else begin
            m_rdy = enable && (!mbusy || mq.size() == 1);
            mdet  = 0;
            if (mbusy) begin
                m_b = mq.pop_front();
                hq.push_back(m_b);
                if (hq.size() > PAT_MAX) void'(hq.pop_front());
                avail++;
                m_ok = (avail >= mlen);
                if (m_ok) begin
                    for (int k = 0; k < mlen; k++) begin
                        if (hq[hq.size() - mlen + k] != int'(mpat[mlen - 1 - k])) m_ok = 0;
                    end
                end
                if (m_ok) begin
                    mdet = 1;
                    if (mcnt < (1 << CNT_W) - 1) mcnt++;
`ifdef DET_NONOVERLAP_EN
                    avail = 0;
`endif
                end
            end
            if (in_valid && m_rdy) begin
                for (int i = DATA_W - 1; i >= 0; i--) mq.push_back(int'(in_data[i]));
                mpat  = cfg_pattern;
                mlen  = (cfg_len == 0) ? 1 : (int'(cfg_len) > PAT_MAX ? PAT_MAX : int'(cfg_len));
                mbusy = 1;
            end else if (mq.size() == 0) begin
                mbusy = 0;
            end
            if (cfg_thresh != 0 && mcnt >= int'(cfg_thresh)) mirq = 1;
        end
    end

    always @(posedge clk) begin
        #1;
        if (!reset) begin
            check("busy", int'(busy), int'(mbusy));
            check("in_ready", int'(in_ready), int'(enable && !clear && (!mbusy || mq.size() == 1)));
            check("det_pulse", int'(det_pulse), int'(mdet));
            check("match_count", int'(match_count), mcnt);
            check("irq", int'(irq), int'(mirq));
            if (det_pulse) pulses.push_back(cyc);
        end
    end

    task automatic send_word(input logic [DATA_W-1:0] d, output int acc);
        int n;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        n = 0;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check("accept_timeout", 0, 1);
        acc = cyc + 1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic do_clear();
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    int a0, a1, a2;

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        cfg_len     = 4'd3;
        cfg_pattern = 8'b101;
        enable      = 1'b1;
        #12;
        check("rst_busy", int'(busy), 0);
        check("rst_det", int'(det_pulse), 0);
        check("rst_count", int'(match_count), 0);
        check("rst_irq", int'(irq), 0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_in_ready", int'(in_ready), 1);

        // 101 over 1010_1000
        pulses.delete();
        send_word(8'b1010_1000, a0);
        repeat (12) @(posedge clk);
        #2;
`ifdef DET_NONOVERLAP_EN
        check("t1_npulse", pulses.size(), 1);
        check("t1_count", int'(match_count), 1);
`else
        check("t1_npulse", pulses.size(), 2);
        check("t1_count", int'(match_count), 2);
        if (pulses.size() == 2) check("t1_p1", pulses[1], a0 + 5);
`endif
        if (pulses.size() >= 1) check("t1_p0", pulses[0], a0 + 3);

        // cross-word 01, 40
        do_clear();
        #1;
        check("clr_count", int'(match_count), 0);
        pulses.delete();
        send_word(8'h01, a0);
        send_word(8'h40, a1);
        repeat (12) @(posedge clk);
        #2;
        check("xw_accept_gap", a1 - a0, 8);
        check("xw_npulse", pulses.size(), 1);
        if (pulses.size() == 1) check("xw_p0", pulses[0], a0 + 10);

        // threshold with 10 over AA
        do_clear();
        cfg_len     = 4'd2;
        cfg_pattern = 8'b10;
        cfg_thresh  = 4'd3;
        send_word(8'hAA, a0);
        send_word(8'hAA, a1);
        repeat (12) @(posedge clk);
        #2;
        check("th_count", int'(match_count), 8);
        check("th_irq", int'(irq), 1);
        enable = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        check("th_irq_hold", int'(irq), 1);
        do_clear();
        #1;
        check("th_clr_irq", int'(irq), 0);
        check("th_clr_count", int'(match_count), 0);
        enable = 1'b1;

        // saturation with 11 over five FF words
        cfg_thresh  = 4'd0;
        cfg_pattern = 8'b11;
        pulses.delete();
        for (int w = 0; w < 5; w++) send_word(8'hFF, a0);
        repeat (12) @(posedge clk);
        #2;
`ifdef DET_NONOVERLAP_EN
        check("sat_npulse", pulses.size(), 20);
`else
        check("sat_npulse", pulses.size(), 39);
`endif
        check("sat_count", int'(match_count), 15);

        // clear at bit_idx 3 of FF
        do_clear();
        pulses.delete();
        send_word(8'hFF, a0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        #1;
        check("mc_busy", int'(busy), 0);
        check("mc_in_ready", int'(in_ready), 1);
        repeat (10) @(posedge clk);
        #2;
`ifdef DET_NONOVERLAP_EN
        check("mc_npulse", pulses.size(), 1);
`else
        check("mc_npulse", pulses.size(), 2);
        if (pulses.size() == 2) check("mc_p1", pulses[1], a0 + 3);
`endif
        if (pulses.size() >= 1) check("mc_p0", pulses[0], a0 + 2);

        // async reset in the last bit of 0000_0101, then 1000_0000 must not match 101
        do_clear();
        cfg_len     = 4'd3;
        cfg_pattern = 8'b101;
        pulses.delete();
        send_word(8'h05, a0);
        repeat (7) @(posedge clk);
        #1;
        check("ar_busy_before", int'(busy), 1);
        #2;
        reset = 1'b1;
        #1;
        check("ar_busy", int'(busy), 0);
        check("ar_det", int'(det_pulse), 0);
        check("ar_count", int'(match_count), 0);
        check("ar_irq", int'(irq), 0);
        @(negedge clk);
        reset = 1'b0;
        send_word(8'h80, a1);
        repeat (12) @(posedge clk);
        #2;
        check("ar_npulse", pulses.size(), 0);
        check("ar_count_after", int'(match_count), 0);

        // randomized traffic, checked by the per-cycle compare process
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            enable   = ($urandom_range(0, 9) != 0);
            in_valid = ($urandom_range(0, 3) != 0);
            in_data  = DATA_W'($urandom);
            clear    = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 49) == 0) begin
                cfg_pattern = PAT_MAX'($urandom);
                cfg_len     = ($urandom_range(0, 1) == 0) ? LEN_W'($urandom_range(0, 4))
                                                          : LEN_W'($urandom_range(0, 15));
                cfg_thresh  = CNT_W'($urandom_range(0, 15));
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        clear    = 1'b0;
        repeat (12) @(posedge clk);
        #2;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
